shift_reg_sequencer: RTL and testbench

//   Command-driven controller for the bidirectional shift register: accepts a shift job
//   (direction, bit count, serial payload) over a valid/ready handshake.

---
 rtl/shift_reg_sequencer.sv | 156 +++++++++++++++
 tb/tb_shift_reg_sequencer.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_reg_sequencer.sv
// Shift-job sequencer for the bidirectional shift register.
// Optional rotate feedback: define SHIFT_SEQ_ROTATE_EN.
module shift_reg_sequencer #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_dir,
  input  logic [CNT_W-1:0] cmd_cnt,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic             cmd_rot,
  input  logic [WIDTH-1:0] sr_q,
  output logic             sr_en,
  output logic             sr_mode,
  output logic             sr_dr,
  output logic             sr_dl,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] bits_left
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t           r_state, n_state;
  logic             r_ready, n_ready;
  logic             r_en, n_en;
  logic             r_mode, n_mode;
  logic             r_dr, n_dr;
  logic             r_dl, n_dl;
  logic             r_busy, n_busy;
  logic             r_done, n_done;
  logic [CNT_W-1:0] r_left, n_left;
  logic [CNT_W-1:0] r_idx, n_idx;
  logic             r_dir, n_dir;
  logic [WIDTH-1:0] r_data, n_data;
  logic [WIDTH-1:0] w_sh;
  logic             w_acc;

  assign w_acc = cmd_valid & r_ready;

  // Next state and next registered outputs
  always_comb begin
    n_state = r_state;
    n_mode  = r_mode;
    n_left  = r_left;
    n_idx   = r_idx;
    n_dir   = r_dir;
    n_data  = r_data;
    n_en    = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_acc) begin
          n_dir  = cmd_dir;
          n_data = cmd_data;
          n_mode = cmd_dir;
          n_idx  = '0;
          if (cmd_cnt == '0) begin
            n_state = S_DONE;
            n_left  = '0;
          end else begin
            n_state = S_SHIFT;
            n_left  = cmd_cnt - 1'b1;
            n_en    = 1'b1;
          end
        end
      end
      S_SHIFT: begin
        if (r_left == '0) begin
          n_state = S_DONE;
        end else begin
          n_left = r_left - 1'b1;
          n_idx  = r_idx + 1'b1;
          n_en   = 1'b1;
        end
      end
      S_DONE:  n_state = S_IDLE;
      default: n_state = S_IDLE;
    endcase
    // payload bits beyond WIDTH shift out as zero
    w_sh    = n_data >> n_idx;
    n_dr    = n_en & ~n_dir & w_sh[0];
    n_dl    = n_en & n_dir & w_sh[0];
    n_done  = (n_state == S_DONE);
    n_busy  = (n_state != S_IDLE);
    n_ready = (n_state == S_IDLE);
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_ready <= 1'b0;
      r_en    <= 1'b0;
      r_mode  <= 1'b0;
      r_dr    <= 1'b0;
      r_dl    <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_left  <= '0;
      r_idx   <= '0;
      r_dir   <= 1'b0;
      r_data  <= '0;
    end else begin
      r_state <= n_state;
      r_ready <= n_ready;
      r_en    <= n_en;
      r_mode  <= n_mode;
      r_dr    <= n_dr;
      r_dl    <= n_dl;
      r_busy  <= n_busy;
      r_done  <= n_done;
      r_left  <= n_left;
      r_idx   <= n_idx;
      r_dir   <= n_dir;
      r_data  <= n_data;
    end
  end

`ifdef SHIFT_SEQ_ROTATE_EN
  logic r_rot;

  // Capture the rotate request with the job
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rot <= 1'b0;
    end else if (w_acc) begin
      r_rot <= cmd_rot;
    end
  end

  assign sr_dr = (r_rot & r_en) ?
                 (~r_dir & sr_q[0]) : r_dr;
  assign sr_dl = (r_rot & r_en) ?
                 (r_dir & sr_q[WIDTH-1]) : r_dl;
`else
  logic w_unused;
  assign w_unused = ^{cmd_rot, sr_q};
  assign sr_dr    = r_dr;
  assign sr_dl    = r_dl;
`endif

  assign cmd_ready = r_ready;
  assign sr_en     = r_en;
  assign sr_mode   = r_mode;
  assign busy      = r_busy;
  assign done      = r_done;
  assign bits_left = r_left;

endmodule

// File: tb/tb_shift_reg_sequencer.sv
// Self-checking bench for shift_reg_sequencer.
// Drives a model shift register fed back to sr_q.
module tb_shift_reg_sequencer;

  localparam int W = 4;
  localparam int C = 4;
`ifdef SHIFT_SEQ_ROTATE_EN
  localparam bit ROT_ON = 1'b1;
`else
  localparam bit ROT_ON = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         cmd_valid = 1'b0;
  logic         cmd_ready;
  logic         cmd_dir = 1'b0;
  logic [C-1:0] cmd_cnt = '0;
  logic [W-1:0] cmd_data = '0;
  logic         cmd_rot = 1'b0;
  logic [W-1:0] sreg;
  logic         sr_en, sr_mode, sr_dr, sr_dl;
  logic         busy, done;
  logic [C-1:0] bits_left;
  logic         ld = 1'b0;
  logic [W-1:0] ld_val = '0;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  shift_reg_sequencer #(.WIDTH(W), .CNT_W(C)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_dir(cmd_dir), .cmd_cnt(cmd_cnt),
    .cmd_data(cmd_data), .cmd_rot(cmd_rot),
    .sr_q(sreg), .sr_en(sr_en), .sr_mode(sr_mode),
    .sr_dr(sr_dr), .sr_dl(sr_dl), .busy(busy),
    .done(done), .bits_left(bits_left)
  );

  // The shift register being sequenced
  always_ff @(posedge clk) begin
    if (ld) sreg <= ld_val;
    else if (sr_en)
      sreg <= sr_mode ? {sreg[W-2:0], sr_dl}
                      : {sr_dr, sreg[W-1:1]};
  end

  typedef struct {
    logic         dir;
    logic [C-1:0] cnt;
    logic [W-1:0] data;
    logic         rot;
    logic [W-1:0] pre;
    logic [W-1:0] exp_norot;
    logic [W-1:0] exp_rot;
  } vec_t;

  vec_t tbl[7];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  function automatic logic inj_bit(
      input int i, input logic dir,
      input logic [W-1:0] data, input logic rot,
      input logic [W-1:0] pre);
    if (rot && ROT_ON)
      return dir ? pre[(W-1) - (i % W)] : pre[i % W];
    return (i < W) ? data[i] : 1'b0;
  endfunction

  function automatic logic [W-1:0] final_of(
      input logic dir, input int cnt,
      input logic [W-1:0] data, input logic rot,
      input logic [W-1:0] pre);
    int r = int'(pre);
    for (int i = 0; i < cnt; i++) begin
      int b = int'(inj_bit(i, dir, data, rot, pre));
      if (dir) r = ((r * 2) + b) % (1 << W);
      else     r = (r / 2) + b * (1 << (W-1));
    end
    return W'(r);
  endfunction

  task automatic preload(input logic [W-1:0] v);
    ld = 1'b1;
    ld_val = v;
    @(negedge clk);
    ld = 1'b0;
  endtask

  task automatic wait_ready();
    int t = 0;
    while (cmd_ready !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("ready_wait", cmd_ready, 1);
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_rdy"}, cmd_ready, 0);
    chk({nm, "_en"}, sr_en, 0);
    chk({nm, "_mode"}, sr_mode, 0);
    chk({nm, "_dr"}, sr_dr, 0);
    chk({nm, "_dl"}, sr_dl, 0);
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_done"}, done, 0);
    chk({nm, "_left"}, bits_left, 0);
  endtask

  task automatic run_job(
      input logic dir, input logic [C-1:0] cnt,
      input logic [W-1:0] data, input logic rot,
      input logic [W-1:0] pre,
      output logic [W-1:0] fin);
    logic b;
    preload(pre);
    wait_ready();
    cmd_dir = dir; cmd_cnt = cnt;
    cmd_data = data; cmd_rot = rot;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_dir = ~dir; cmd_data = ~data;
    cmd_cnt = C'($urandom); cmd_rot = ~rot;
    for (int i = 0; i < int'(cnt); i++) begin
      b = inj_bit(i, dir, data, rot, pre);
      chk("en", sr_en, 1);
      chk("mode", sr_mode, dir);
      chk("dr", sr_dr, dir ? 1'b0 : b);
      chk("dl", sr_dl, dir ? b : 1'b0);
      chk("left", bits_left, int'(cnt) - 1 - i);
      chk("busy", busy, 1);
      chk("rdy_sh", cmd_ready, 0);
      chk("done_sh", done, 0);
      @(negedge clk);
    end
    chk("done", done, 1);
    chk("en_dn", sr_en, 0);
    chk("busy_dn", busy, 1);
    chk("rdy_dn", cmd_ready, 0);
    chk("dr_dn", sr_dr, 0);
    chk("dl_dn", sr_dl, 0);
    chk("left_dn", bits_left, 0);
    if (cnt != 0) chk("mode_dn", sr_mode, dir);
    @(negedge clk);
    chk("done_off", done, 0);
    chk("busy_off", busy, 0);
    chk("rdy_back", cmd_ready, 1);
    chk("final", sreg,
        final_of(dir, int'(cnt), data, rot, pre));
    fin = sreg;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] fin;
    logic [W-1:0] ex;
    tbl[0] = '{0, 4,  4'b1011, 0, 4'b0000, 4'b1011, 4'b1011};
    tbl[1] = '{1, 6,  4'b0110, 0, 4'b0000, 4'b1000, 4'b1000};
    tbl[2] = '{0, 0,  4'b1111, 0, 4'b0101, 4'b0101, 4'b0101};
    tbl[3] = '{1, 4,  4'b0011, 1, 4'b1001, 4'b1100, 4'b1001};
    tbl[4] = '{0, 7,  4'b1111, 0, 4'b0000, 4'b0001, 4'b0001};
    tbl[5] = '{0, 2,  4'b1111, 1, 4'b0110, 4'b1101, 4'b1001};
    tbl[6] = '{1, 15, 4'b1010, 0, 4'b1111, 4'b0000, 4'b0000};

    ld = 1'b1;
    ld_val = '0;
    #1;
    chk_zero("rst");
    @(negedge clk);
    @(negedge clk);
    ld = 1'b0;
    rst = 1'b1;
    #1;
    chk("rdy_rel", cmd_ready, 0);
    @(negedge clk);
    chk("rdy_1st", cmd_ready, 1);

    // reset in the middle of a left job
    cmd_dir = 1; cmd_cnt = 5;
    cmd_data = 4'b1111; cmd_valid = 1;
    @(negedge clk);
    cmd_valid = 0;
    @(negedge clk);
    chk("mid_en", sr_en, 1);
    chk("mid_dl", sr_dl, 1);
    #2;
    rst = 1'b0;
    #1;
    chk_zero("mrst");
    @(negedge clk);
    chk("mrst_done", done, 0);
    rst = 1'b1;
    @(negedge clk);
    chk("mrst_rdy", cmd_ready, 1);
    chk("mrst_busy", busy, 0);
    @(negedge clk);
    chk("mrst_nodone", done, 0);

    // directed table
    foreach (tbl[j]) begin
      run_job(tbl[j].dir, tbl[j].cnt, tbl[j].data,
              tbl[j].rot, tbl[j].pre, fin);
      ex = ROT_ON ? tbl[j].exp_rot : tbl[j].exp_norot;
      chk($sformatf("tbl%0d", j), fin, ex);
    end

    // back-to-back null jobs with valid held
    wait_ready();
    cmd_cnt = 0; cmd_dir = 0; cmd_valid = 1;
    @(negedge clk);
    chk("n1_done", done, 1);
    chk("n1_rdy", cmd_ready, 0);
    chk("n1_en", sr_en, 0);
    chk("n1_busy", busy, 1);
    @(negedge clk);
    chk("n1_off", done, 0);
    chk("n1_back", cmd_ready, 1);
    @(negedge clk);
    chk("n2_done", done, 1);
    chk("n2_busy", busy, 1);
    cmd_valid = 0;
    @(negedge clk);
    chk("n2_off", done, 0);
    chk("n2_back", cmd_ready, 1);

    // new command held during SHIFT waits for done
    preload(4'b0000);
    cmd_dir = 0; cmd_cnt = 4;
    cmd_data = 4'b1011; cmd_valid = 1;
    @(negedge clk);
    cmd_dir = 1; cmd_cnt = 2; cmd_data = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      ex = 4'b1011;
      chk("hold_en", sr_en, 1);
      chk("hold_mode", sr_mode, 0);
      chk("hold_dr", sr_dr, ex[i]);
      @(negedge clk);
    end
    chk("hold_done", done, 1);
    chk("hold_sreg", sreg, 4'b1011);
    @(negedge clk);
    chk("hold_rdy", cmd_ready, 1);
    @(negedge clk);
    cmd_valid = 0;
    chk("q2_en", sr_en, 1);
    chk("q2_mode", sr_mode, 1);
    chk("q2_left", bits_left, 1);
    @(negedge clk);
    chk("q2_left0", bits_left, 0);
    @(negedge clk);
    chk("q2_done", done, 1);
    @(negedge clk);
    chk("q2_sreg", sreg, 4'b1100);

    // randomized jobs against the model
    for (int r = 0; r < 40; r++) begin
      run_job(1'($urandom), C'($urandom),
              W'($urandom), 1'($urandom),
              W'($urandom), fin);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
